i2c_master_tx: RTL and testbench
================================

Name: i2c_master_tx

Overview:
Synthesizable I2C-style master transmitter. It serializes one DATA_WIDTH-bit word onto scl/sda, framed by START, one ACK slot and STOP. It is the driving end for the team's i2c_slave bench model; sda_master_en is the handshake that tells that slave when the master owns the line. It sits behind the APB register block, which hands it words over a valid/ready interface.

Parameters:
DATA_WIDTH, 32, bits per transfer, sent LSB first (the slave shifts in at the MSB, so the first bit sent lands at bit 0).
CLK_DIV, 4, clk cycles per SCL quarter-period; must be >= 2 (elaboration error otherwise).

Ports:
clk  input  1  system clock; all logic is on posedge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  word to send
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block is idle and will accept a word
scl  output  1  serial clock
sda_out  output  1  SDA value driven when sda_master_en=1
sda_master_en  output  1  1 = master drives SDA; 0 = line released to the slave
sda_in  input  1  sampled SDA line, used for ACK
done  output  1  one-cycle pulse when a transfer completes
ack_err  output  1  1 = last transfer was NACKed; holds until the next transfer completes

Behaviour:
- Reset (async, rst_n=0): state=IDLE, scl=1, sda_out=1, sda_master_en=1, tx_ready=1, done=0, ack_err=0, all counters=0.
- Timing unit: quarter tick Q = CLK_DIV clk cycles. Each non-IDLE state runs phases p0..p3, one Q each.
- Accept: in IDLE, tx_valid&tx_ready at a posedge does three things on that edge: latches tx_data into the shift register, clears the bit count, and enters START. tx_ready falls on the same edge.
- tx_valid while busy is ignored; there is no queue.
- IDLE: scl=1, sda_out=1, en=1.
- START: p0 scl=1 sda=1; p1 scl=1 sda=0 (start condition); p2,p3 scl=0 sda=0. Then BIT.
- BIT (DATA_WIDTH times): p0 scl=0, sda_out=shreg[0]; p1,p2 scl=1; p3 scl=0 (negedge at start of p3, slave samples then). SDA holds through p3. Shift right at the end of p3. After the last bit, go to ACK.
- SDA changes only at p0 of BIT, which is Q (>= 2 clk) after the SCL negedge. This guarantees hold for the slave's sample one clk after the negedge.
- ACK: same scl pattern with en=0 for all four phases. Register sda_in at the last cycle of p2; 1 = NACK. Then STOP.
- STOP: p0 scl=0 sda=0 en=1; p1 scl=1 sda=0; p2,p3 scl=1 sda=1 (stop condition at p2 start). Then IDLE.
- On entry to IDLE: done=1 for exactly one cycle, ack_err updated, tx_ready=1.
- A new word may be accepted in that same done cycle. Back-to-back transfers therefore have zero idle gap beyond START p0.
- Latency: accept to done = (DATA_WIDTH+3)*4*CLK_DIV cycles. Defaults give 35*16 = 560.
- NACK does not abort; STOP is always sent.
- Reset mid-transfer: outputs return immediately to the IDLE values (lines released high). No stop sequence is generated; the shift register contents are discarded.
- SDA never changes while scl=1, except the START p1 and STOP p2 edges.
- Outputs scl, sda_out and sda_master_en are registered (glitch-free).

Decomposition:
- Package i2c_pkg:
  - state enum {IDLE, START, BIT, ACK, STOP};
  - 2-bit phase typedef;
  - localparam BITCNT_W = $clog2(DATA_WIDTH+1);
  - function for the CLK_DIV counter width.
- Sub-module i2c_qtick_gen:
  - free-running quarter-tick divider, enabled while not IDLE;
  - outputs a tick pulse and the 2-bit phase;
  - cleared on rst_n or on accept.
- FSM, shift register and bit counter stay in i2c_master_tx.

Test Plan:
- Single word, defaults, send 32'hA5A5_0F0F with i2c_slave attached -> slave data_r=32'hA5A5_0F0F with data_r_vld; done exactly 560 cycles after accept; ack_err=0.
- NACK: ACK slot with sda_in held 1 -> ack_err=1 at done; STOP still seen; next ACKed transfer clears ack_err to 0.
- Back-to-back: tx_valid held high with 32'h0000_0001 then 32'hFFFF_FFFF -> second accepted in the done cycle of the first; slave receives both in order.
- Busy ignore: pulse tx_valid with 32'hDEAD_BEEF mid-transfer -> tx_ready=0, word dropped, in-flight word unaffected.
- Reset at bit 10 -> scl=1, sda_out=1, en=1, tx_ready=1 asynchronously; a following transfer of 32'h1234_5678 completes correctly.
- Protocol checker assertion, CLK_DIV=2: sda changes only while scl=0, except START/STOP edges -> zero violations.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and width helpers for the I2C master transmitter.
`timescale 1ns/1ps
package i2c_pkg;

    // Transfer sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Quarter-period index within a state (p0..p3).
    typedef logic [1:0] phase_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BITCNT_W           = $clog2(DEFAULT_DATA_WIDTH + 1);

    // Bit counter width able to hold 0..dw.
    function automatic int bitcnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

    // Divider counter width able to hold 0..div-1.
    function automatic int div_cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick divider: one tick every CLK_DIV clocks while enabled,
// plus a 2-bit phase that advances on each tick.
`timescale 1ns/1ps
module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   clr,
    output logic   tick,
    output phase_t phase
);

    localparam int CW = div_cnt_width(CLK_DIV);

    logic [CW-1:0] cnt_r;
    phase_t        phase_r;
    logic          wrap_s;

    assign wrap_s = (cnt_r == CW'(CLK_DIV - 1));
    assign tick   = en && wrap_s;
    assign phase  = phase_r;

    // Divider count and phase; a new transfer restarts both from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            phase_r <= 2'd0;
        end else if (clr) begin
            cnt_r   <= '0;
            phase_r <= 2'd0;
        end else if (en) begin
            if (wrap_s) begin
                cnt_r   <= '0;
                phase_r <= phase_r + 2'd1;
            end else begin
                cnt_r   <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// I2C-style master transmitter: START, DATA_WIDTH bits LSB first, one ACK
// slot, STOP. Line outputs are registered from the next-cycle state so they
// change exactly on phase boundaries without glitches.
`timescale 1ns/1ps
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  scl,
    output logic                  sda_out,
    output logic                  sda_master_en,
    input  logic                  sda_in,
    output logic                  done,
    output logic                  ack_err
);

    localparam int BCW = bitcnt_width(DATA_WIDTH);

    generate
        if (CLK_DIV < 2) begin : g_div_check
            $error("i2c_master_tx: CLK_DIV must be >= 2");
        end
    endgenerate

    state_t                state_r, state_nxt_s;
    phase_t                phase_s, phase_nxt_s;
    logic                  tick_s, accept_s, phase_end_s, last_bit_s, qtick_en_s;
    logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt_s;
    logic [BCW-1:0]        bitcnt_r;
    logic                  ack_smp_r;
    logic                  scl_r, sda_r, en_r, ready_r, done_r, ack_err_r;
    logic                  scl_nxt_s, sda_nxt_s, en_nxt_s;

    assign qtick_en_s  = (state_r != IDLE);
    assign accept_s    = (state_r == IDLE) && tx_valid && ready_r;
    assign phase_end_s = tick_s && (phase_s == 2'd3);
    assign last_bit_s  = (bitcnt_r == BCW'(DATA_WIDTH - 1));

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (qtick_en_s),
        .clr   (accept_s),
        .tick  (tick_s),
        .phase (phase_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: every non-idle state lasts four phases.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (accept_s)    state_nxt_s = START; else state_nxt_s = IDLE;
            START:   if (phase_end_s) state_nxt_s = BIT;   else state_nxt_s = START;
            BIT: begin
                if (phase_end_s) begin
                    if (last_bit_s) state_nxt_s = ACK;
                    else            state_nxt_s = BIT;
                end else begin
                    state_nxt_s = BIT;
                end
            end
            ACK:     if (phase_end_s) state_nxt_s = STOP;  else state_nxt_s = ACK;
            STOP:    if (phase_end_s) state_nxt_s = IDLE;  else state_nxt_s = STOP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next phase and next shift-register value, used to pre-compute line outputs.
    always_comb begin
        phase_nxt_s = phase_s;
        shreg_nxt_s = shreg_r;
        if (accept_s) begin
            phase_nxt_s = 2'd0;
            shreg_nxt_s = tx_data;
        end else begin
            if (tick_s) phase_nxt_s = phase_s + 2'd1;
            else        phase_nxt_s = phase_s;
            if ((state_r == BIT) && phase_end_s) shreg_nxt_s = shreg_r >> 1;
            else                                 shreg_nxt_s = shreg_r;
        end
    end

    // Shift register, bit counter and ACK sample (taken on the last clock of ACK p2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= '0;
            bitcnt_r  <= '0;
            ack_smp_r <= 1'b0;
        end else begin
            shreg_r <= shreg_nxt_s;
            if (accept_s) begin
                bitcnt_r <= '0;
            end else if ((state_r == BIT) && phase_end_s) begin
                bitcnt_r <= bitcnt_r + BCW'(1);
            end
            if ((state_r == ACK) && tick_s && (phase_s == 2'd2)) begin
                ack_smp_r <= sda_in;
            end
        end
    end

    // Line levels for the upcoming cycle; SDA only moves while SCL is low
    // except for the deliberate START and STOP edges.
    always_comb begin
        scl_nxt_s = 1'b1;
        sda_nxt_s = 1'b1;
        en_nxt_s  = 1'b1;
        case (state_nxt_s)
            IDLE: begin
                scl_nxt_s = 1'b1;
                sda_nxt_s = 1'b1;
            end
            START: begin
                scl_nxt_s = (phase_nxt_s == 2'd0) || (phase_nxt_s == 2'd1);
                sda_nxt_s = (phase_nxt_s == 2'd0);
            end
            BIT: begin
                scl_nxt_s = (phase_nxt_s == 2'd1) || (phase_nxt_s == 2'd2);
                sda_nxt_s = shreg_nxt_s[0];
            end
            ACK: begin
                scl_nxt_s = (phase_nxt_s == 2'd1) || (phase_nxt_s == 2'd2);
                sda_nxt_s = 1'b1;
                en_nxt_s  = 1'b0;
            end
            STOP: begin
                scl_nxt_s = (phase_nxt_s != 2'd0);
                sda_nxt_s = (phase_nxt_s == 2'd2) || (phase_nxt_s == 2'd3);
            end
            default: begin
                scl_nxt_s = 1'b1;
                sda_nxt_s = 1'b1;
            end
        endcase
    end

    // Registered outputs; completion pulses on the edge that returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_r     <= 1'b1;
            sda_r     <= 1'b1;
            en_r      <= 1'b1;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            scl_r   <= scl_nxt_s;
            sda_r   <= sda_nxt_s;
            en_r    <= en_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            done_r  <= (state_r == STOP) && phase_end_s;
            if ((state_r == STOP) && phase_end_s) begin
                ack_err_r <= ack_smp_r;
            end
        end
    end

    assign scl           = scl_r;
    assign sda_out       = sda_r;
    assign sda_master_en = en_r;
    assign tx_ready      = ready_r;
    assign done          = done_r;
    assign ack_err       = ack_err_r;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: cycle-level transaction model, bus decoder that
// rebuilds received words from scl/sda, and a START/STOP edge monitor on a
// default instance and a CLK_DIV=2 instance.
`timescale 1ns/1ps
module tb_i2c_master_tx;

    localparam int DW    = 32;
    localparam int D     = 4;
    localparam int LAT   = (DW + 3) * 4 * D;
    localparam int ACK_N = (DW + 1) * 4 * D + 2 * D + 1;

    typedef struct {
        logic [31:0] data;
        logic        nack;
        logic [31:0] exp_rx;
        logic        exp_ack_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          sda_in = 1'b0;
    logic          tx_ready, scl, sda_out, sda_master_en, done, ack_err;
    logic          tx_ready2, scl2, sda_out2, sda_master_en2, done2, ack_err2;

    always #5 clk = ~clk;

    i2c_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .scl(scl), .sda_out(sda_out),
        .sda_master_en(sda_master_en), .sda_in(sda_in), .done(done), .ack_err(ack_err)
    );

    i2c_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready2), .scl(scl2), .sda_out(sda_out2),
        .sda_master_en(sda_master_en2), .sda_in(sda_in), .done(done2), .ack_err(ack_err2)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transaction model: accept when idle, done LAT cycles later, ACK sampled mid ACK slot.
    bit            m_busy = 1'b0, m_done = 1'b0, m_ack = 1'b0, m_ack_err = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] exp_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_ack = 1'b0; m_ack_err = 1'b0; m_cnt = 0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (tx_valid) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    exp_q.push_back(tx_data);
                end
            end else begin
                m_cnt++;
                if (m_cnt == ACK_N) m_ack = sda_in;
                if (m_cnt == LAT) begin
                    m_busy    = 1'b0;
                    m_done    = 1'b1;
                    m_ack_err = m_ack;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("tx_ready", tx_ready, !m_busy);
        chk("done", done, m_done);
        chk("ack_err", ack_err, m_ack_err);
    end

    // Bus decoder on the default instance.
    bit            in_frame = 1'b0, d_pscl = 1'b1, d_pline = 1'b1, d_line;
    int            bitpos = 0;
    logic [DW-1:0] rx = '0, last_rx = '0;

    initial forever begin
        @(negedge clk);
        d_line = sda_master_en ? sda_out : 1'b1;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else if (d_pscl && scl && d_pline && !d_line) begin
            in_frame = 1'b1; bitpos = 0; rx = '0;
        end else if (d_pscl && scl && !d_pline && d_line) begin
            if (in_frame) begin
                chk("rx_bit_count", bitpos, DW);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rx_frame: got frame %h, expected no frame", rx);
                end else begin
                    chk("rx_word", rx, exp_q.pop_front());
                end
                last_rx = rx;
            end
            in_frame = 1'b0;
        end else if (!d_pscl && scl && sda_master_en && in_frame && bitpos < DW) begin
            rx[bitpos] = sda_out;
            bitpos++;
        end
        d_pscl  = scl;
        d_pline = d_line;
    end

    // START/STOP edge monitor on both instances: the only SDA edges while SCL is high.
    int   falls[2], rises[2], dones[2];
    logic c_scl[2], c_line[2], c_done[2], p_scl[2], p_line[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            falls[i] = 0; rises[i] = 0; dones[i] = 0; p_scl[i] = 1'b1; p_line[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            c_scl[0] = scl;  c_line[0] = sda_master_en  ? sda_out  : 1'b1; c_done[0] = done;
            c_scl[1] = scl2; c_line[1] = sda_master_en2 ? sda_out2 : 1'b1; c_done[1] = done2;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    falls[i] = 0; rises[i] = 0; dones[i] = 0;
                end else begin
                    if (p_scl[i] && c_scl[i] && p_line[i] && !c_line[i]) falls[i]++;
                    if (p_scl[i] && c_scl[i] && !p_line[i] && c_line[i]) rises[i]++;
                    if (c_done[i]) dones[i]++;
                end
                p_scl[i]  = c_scl[i];
                p_line[i] = c_line[i];
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL wait_ready: got timeout, expected tx_ready=1");
        end
    endtask

    task automatic start_word(input logic [31:0] d, input logic nack, output int acc);
        wait_ready();
        tx_data  = d;
        sda_in   = nack;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic finish_word(input int acc, input logic [31:0] exp_rx, input logic exp_ack);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL wait_done: got timeout, expected done pulse");
        end else begin
            chk("latency", cyc - acc, LAT);
            chk("ack_err_at_done", ack_err, exp_ack);
            chk("rx_last", last_rx, exp_rx);
        end
    endtask

    vec_t vecs[4];

    initial begin
        int acc, a1, a2;
        logic [31:0] rd;
        logic rn;

        vecs[0] = '{32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1'b0};
        vecs[1] = '{32'h0F0F_A5A5, 1'b1, 32'h0F0F_A5A5, 1'b1};
        vecs[2] = '{32'h3C3C_C3C3, 1'b0, 32'h3C3C_C3C3, 1'b0};
        vecs[3] = '{32'h8000_0001, 1'b1, 32'h8000_0001, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda_out, 1);
        chk("rst_en", sda_master_en, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            start_word(vecs[i].data, vecs[i].nack, acc);
            finish_word(acc, vecs[i].exp_rx, vecs[i].exp_ack_err);
        end

        // Back-to-back with tx_valid held: second word taken in the done cycle.
        wait_ready();
        tx_data = 32'h0000_0001; sda_in = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        a1 = cyc;
        tx_data = 32'hFFFF_FFFF;
        finish_word(a1, 32'h0000_0001, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        a2 = cyc;
        chk("b2b_second_accepted", tx_ready, 0);
        finish_word(a2, 32'hFFFF_FFFF, 1'b0);

        // Busy ignore: a word offered mid-transfer is dropped.
        start_word(32'h5A5A_C3C3, 1'b0, acc);
        repeat (100) @(negedge clk);
        tx_data = 32'hDEAD_BEEF; tx_valid = 1'b1;
        chk("busy_ready", tx_ready, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        finish_word(acc, 32'h5A5A_C3C3, 1'b0);
        repeat (20) @(negedge clk);
        chk("idle_after_busy", tx_ready, 1);

        // Asynchronous reset during bit 10 (p0, SCL low), then a clean transfer.
        start_word(32'hCAFE_F00D, 1'b0, acc);
        while (cyc < acc + 177) @(negedge clk);
        chk("pre_reset_scl_low", scl, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_scl", scl, 1);
        chk("async_rst_sda", sda_out, 1);
        chk("async_rst_en", sda_master_en, 1);
        chk("async_rst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_word(32'h1234_5678, 1'b0, acc);
        finish_word(acc, 32'h1234_5678, 1'b0);

        // Random words and random ACK/NACK.
        for (int i = 0; i < 6; i++) begin
            rd = $urandom;
            rn = 1'($urandom_range(0, 1));
            start_word(rd, rn, acc);
            finish_word(acc, rd, rn);
        end

        tx_valid = 1'b0;
        repeat (700) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 2; i++) begin
            chk("transfers_seen", dones[i] > 0, 1);
            chk("start_edges", falls[i], dones[i]);
            chk("stop_edges", rises[i], dones[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
